// File: rtl/conv_encoding.sv
// Rate-1/2 K=7 convolutional encoder (133/171 octal), byte in, one pair per clock.
// Define CONV_TAIL_EN to append an 8-bit zero tail that terminates the trellis.
module conv_encoding (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] din,
  input  logic       indicator,
  output logic [1:0] dout,
  output logic       next_indicator
);

`ifdef CONV_TAIL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1
  } state_e;
`endif

  state_e     state_q;
  logic [2:0] phase_q;
  logic [2:0] phase_d;
  logic [7:0] byte_q;
  logic [5:0] s_q;
  logic [5:0] s_d;
  logic [1:0] dout_q;
  logic       nind_q;
  logic       cur_bit;
  logic [1:0] pair;

  // Bit 0 of a byte comes straight from din; later bits from the latched copy.
  always_comb begin
    cur_bit = 1'b0;
    if (state_q == ENC) begin
      if (phase_q == 3'd0) cur_bit = din[0];
      else                 cur_bit = byte_q[phase_q];
    end
    pair[1] = cur_bit ^ s_q[1] ^ s_q[2] ^ s_q[4] ^ s_q[5];
    pair[0] = cur_bit ^ s_q[0] ^ s_q[1] ^ s_q[2] ^ s_q[5];
    s_d     = {s_q[4:0], cur_bit};
    phase_d = phase_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= 3'd0;
      byte_q  <= 8'd0;
      s_q     <= 6'd0;
      dout_q  <= 2'b00;
      nind_q  <= 1'b0;
    end else begin
      nind_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          s_q     <= 6'd0;
          phase_q <= 3'd0;
          byte_q  <= 8'd0;
          dout_q  <= 2'b00;
          if (indicator) begin
            state_q <= ENC;
            nind_q  <= 1'b1;
          end
        end
        ENC: begin
          dout_q  <= pair;
          s_q     <= s_d;
          phase_q <= phase_d;
          if (phase_q == 3'd0) byte_q <= din;
          if (indicator) begin
`ifdef CONV_TAIL_EN
            state_q <= TAIL;
            phase_q <= 3'd0;
`else
            state_q <= IDLE;
            s_q     <= 6'd0;
            phase_q <= 3'd0;
            byte_q  <= 8'd0;
            nind_q  <= 1'b1;
`endif
          end
        end
`ifdef CONV_TAIL_EN
        TAIL: begin
          dout_q  <= pair;
          s_q     <= s_d;
          phase_q <= phase_d;
          if (phase_q == 3'd7) begin
            state_q <= IDLE;
            s_q     <= 6'd0;
            phase_q <= 3'd0;
            byte_q  <= 8'd0;
            nind_q  <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          s_q     <= 6'd0;
          phase_q <= 3'd0;
          byte_q  <= 8'd0;
          dout_q  <= 2'b00;
        end
      endcase
    end
  end

  assign dout           = dout_q;
  assign next_indicator = nind_q;

endmodule

// File: tb/tb_conv_encoding.sv
// Directed bench for conv_encoding: reset, impulse, zero bytes,
// mid-frame reset, frame end with or without the zero tail.
module tb_conv_encoding;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] din = 8'd0;
  logic       indicator = 1'b0;
  logic [1:0] dout;
  logic       next_indicator;

  int tests = 0;
  int fails = 0;

  logic [1:0] imp [8];
  logic [1:0] tl  [8];
  logic [1:0] ff3 [3];

  always #5 clk = ~clk;

  conv_encoding dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .din            (din),
    .indicator      (indicator),
    .dout           (dout),
    .next_indicator (next_indicator)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] d,
                      input logic n);
    check({tag, ".dout"}, dout, d);
    check({tag, ".nind"}, {1'b0, next_indicator}, {1'b0, n});
  endtask

  initial begin
    imp = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00};
    tl  = '{2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
    ff3 = '{2'b11, 2'b10, 2'b01};

    // Reset held three cycles, then idle with no indicator
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk2("rst_hold", 2'b00, 1'b0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk2("rst_idle", 2'b00, 1'b0);
    end

    // Impulse: byte 0x01, then byte 0x00, then 0xFF aborted by reset
    indicator = 1'b1;
    tick();
    chk2("imp_start", 2'b00, 1'b1);
    indicator = 1'b0;
    din = 8'h01;
    for (int i = 0; i < 8; i++) begin
      tick();
      din = 8'h00;
      chk2("imp_pair", imp[i], 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) din = 8'hFF;
      tick();
      chk2("imp_zero", 2'b00, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk2("ff_pair", ff3[i], 1'b0);
    end
    reset_n = 1'b0;
    tick();
    chk2("midrst", 2'b00, 1'b0);
    reset_n = 1'b1;
    din = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk2("midrst_after", 2'b00, 1'b0);
    end

    // Three zero bytes
    indicator = 1'b1;
    tick();
    chk2("zero_start", 2'b00, 1'b1);
    indicator = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk2("zero_pair", 2'b00, 1'b0);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk2("zero_idle", 2'b00, 1'b0);

    // Byte 0x80 with the end marker on phase 7
    indicator = 1'b1;
    tick();
    chk2("end_start", 2'b00, 1'b1);
    indicator = 1'b0;
    din = 8'h80;
    for (int i = 0; i < 7; i++) begin
      tick();
      din = 8'h00;
      chk2("end_data0", 2'b00, 1'b0);
    end
    indicator = 1'b1;
    tick();
    indicator = 1'b0;
`ifdef CONV_TAIL_EN
    chk2("end_last", 2'b11, 1'b0);
    for (int i = 0; i < 8; i++) begin
      indicator = (i == 2);
      tick();
      chk2("tail_pair", tl[i], (i == 7));
    end
    indicator = 1'b0;
    tick();
    chk2("tail_done", 2'b00, 1'b0);
    tick();
    chk2("tail_idle", 2'b00, 1'b0);
`else
    chk2("end_last", 2'b11, 1'b1);
    tick();
    chk2("end_idle", 2'b00, 1'b0);
    indicator = 1'b1;
    tick();
    chk2("restart", 2'b00, 1'b1);
    indicator = 1'b0;
    din = 8'h01;
    tick();
    chk2("restart_pair", 2'b11, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
